// File: rtl/nand_exerciser_pkg.sv
// Shared types and constants for the NAND exerciser: FSM state encoding,
// sweep length and operand widths.
package nand_exerciser_pkg;

    localparam int OP_W        = 2;                          // operand width of the NAND stage
    localparam int VEC_W       = 2 * OP_W;                   // {a,b} vector index width
    localparam int NUM_VECTORS = 16;                         // all operand combinations
    localparam int ERR_W       = $clog2(NUM_VECTORS + 1);    // counts 0..16 without wrap
    localparam logic [VEC_W-1:0] LAST_VEC = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/nand_exerciser_hold.sv
// hold_timer: loadable down-counter that measures how long each vector is
// held on the NAND inputs. After a load it reports expired once HOLD_CYCLES
// cycles (including the load cycle's successor) have elapsed.
module hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Load on DRIVE entry, then count down to zero and stay there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (load) begin
            count_r <= LOAD_VAL;
        end else if (count_r != {CW{1'b0}}) begin
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {CW{1'b0}});

endmodule

// File: rtl/nand_exerciser.sv
// nand_exerciser: walks all 16 {a,b} operand pairs through the 2-bit NAND
// stage, samples dut_out after HOLD_CYCLES cycles and counts mismatches
// against ~(a & b). Reports busy/done, err_count and pass.
// Optional feature macro: NAND_EXERCISER_FAIL_CAPTURE_EN adds the fail_idx
// port holding the index of the first failing vector of the last sweep.
module nand_exerciser
    import nand_exerciser_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  dut_out,
    output logic [OP_W-1:0]  a,
    output logic [OP_W-1:0]  b,
    output logic [VEC_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic             pass
`ifdef NAND_EXERCISER_FAIL_CAPTURE_EN
    ,
    output logic [VEC_W-1:0] fail_idx
`endif
);

    if (HOLD_CYCLES < 1) begin : g_hold_check
        $error("nand_exerciser: HOLD_CYCLES must be >= 1");
    end

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_DRIVE  = DRIVE;
    localparam logic [1:0] ST_SAMPLE = SAMPLE;
    localparam logic [1:0] ST_DONE   = DONE;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic             load_s;
    logic             expired_s;
    logic             accept_s;
    logic             last_s;
    logic             advance_s;
    logic             finish_s;
    logic             mismatch_s;
    logic [ERR_W-1:0] err_next_s;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .expired (expired_s)
    );

    assign accept_s   = (state_r == ST_IDLE) && start;
    assign last_s     = (vec_idx == LAST_VEC);
    assign advance_s  = (state_r == ST_SAMPLE) && !last_s;
    assign finish_s   = (state_r == ST_SAMPLE) && last_s;
    // Golden compare: the NAND stage must return ~(a & b)
    assign mismatch_s = (state_r == ST_SAMPLE) && (dut_out != ~(a & b));
    assign err_next_s = err_count + {{(ERR_W-1){1'b0}}, mismatch_s};

    // Next-state logic; the hold timer is (re)loaded on every DRIVE entry
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_DRIVE;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (expired_s) begin
                    state_next_s = ST_SAMPLE;
                end else begin
                    state_next_s = ST_DRIVE;
                end
            end
            ST_SAMPLE: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRIVE;
                    load_s       = 1'b1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand and index registers: restart at vector 0, step after each non-final sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx <= 4'd0;
            a       <= 2'd0;
            b       <= 2'd0;
        end else if (accept_s) begin
            vec_idx <= 4'd0;
            a       <= 2'd0;
            b       <= 2'd0;
        end else if (advance_s) begin
            vec_idx <= vec_idx + 4'd1;
            {a, b}  <= vec_idx + 4'd1;
        end else begin
            vec_idx <= vec_idx;
            a       <= a;
            b       <= b;
        end
    end

    // Mismatch counter, cleared on accepted start and updated at the end of each SAMPLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 5'd0;
        end else if (accept_s) begin
            err_count <= 5'd0;
        end else if (state_r == ST_SAMPLE) begin
            err_count <= err_next_s;
        end else begin
            err_count <= err_count;
        end
    end

    // Status flags: busy spans the sweep, done pulses in DONE, pass includes the last sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= finish_s;
            if (accept_s) begin
                busy <= 1'b1;
                pass <= 1'b0;
            end else if (finish_s) begin
                busy <= 1'b0;
                pass <= (err_next_s == 5'd0);
            end else begin
                busy <= busy;
                pass <= pass;
            end
        end
    end

`ifdef NAND_EXERCISER_FAIL_CAPTURE_EN
    // First-failure capture: only the first mismatch of a sweep is latched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_idx <= 4'd0;
        end else if (accept_s) begin
            fail_idx <= 4'd0;
        end else if (mismatch_s && (err_count == 5'd0)) begin
            fail_idx <= vec_idx;
        end else begin
            fail_idx <= fail_idx;
        end
    end
`endif

endmodule

// File: tb/tb_nand_exerciser.sv
// Self-checking bench for nand_exerciser. dut0 (HOLD_CYCLES=2) is driven by a
// configurable NAND stage model (real, stuck-high, AND, random fault table);
// dut1 (HOLD_CYCLES=1) exercises back-to-back sweeps.
module tb_nand_exerciser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start0 = 1'b0;
    logic [1:0] dout0;
    logic [1:0] a0, b0;
    logic [3:0] vi0;
    logic       busy0, done0, pass0;
    logic [4:0] err0;

    logic       start1 = 1'b0;
    logic [1:0] dout1;
    logic [1:0] a1, b1;
    logic [3:0] vi1;
    logic       busy1, done1, pass1;
    logic [4:0] err1;

`ifdef NAND_EXERCISER_FAIL_CAPTURE_EN
    logic [3:0] fidx0, fidx1;
`endif

    logic [1:0] mode0 = 2'd0;
    logic [1:0] mask [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nand_exerciser #(.HOLD_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(dout0),
        .a(a0), .b(b0), .vec_idx(vi0), .busy(busy0), .done(done0),
        .err_count(err0), .pass(pass0)
`ifdef NAND_EXERCISER_FAIL_CAPTURE_EN
        , .fail_idx(fidx0)
`endif
    );

    nand_exerciser #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dout1),
        .a(a1), .b(b1), .vec_idx(vi1), .busy(busy1), .done(done1),
        .err_count(err1), .pass(pass1)
`ifdef NAND_EXERCISER_FAIL_CAPTURE_EN
        , .fail_idx(fidx1)
`endif
    );

    // Behaviour of the stage under test for a given mode and operand vector
    function automatic logic [1:0] stage_resp(input logic [1:0] m, input logic [3:0] v);
        logic [1:0] x, y;
        x = v[3:2];
        y = v[1:0];
        case (m)
            2'd0:    return ~(x & y);
            2'd1:    return 2'b11;
            2'd2:    return x & y;
            default: return ~(x & y) ^ mask[v];
        endcase
    endfunction

    always_comb dout0 = stage_resp(mode0, {a0, b0});
    always_comb dout1 = ~(a1 & b1);

    // Reference: errors and first failing vector of a full sweep in a mode
    function automatic int model_errs(input logic [1:0] m);
        int n = 0;
        for (int v = 0; v < 16; v++) begin
            logic [1:0] x, y, golden;
            x = 2'(v >> 2);
            y = 2'(v & 3);
            golden = 2'(~(x & y));
            if (stage_resp(m, 4'(v)) != golden) n++;
        end
        return n;
    endfunction

    function automatic int model_first(input logic [1:0] m);
        for (int v = 0; v < 16; v++) begin
            logic [1:0] x, y, golden;
            x = 2'(v >> 2);
            y = 2'(v & 3);
            golden = 2'(~(x & y));
            if (stage_resp(m, 4'(v)) != golden) return v;
        end
        return 0;
    endfunction

    // Runs one dut0 sweep for 70 cycles after the start edge, recording observations
    task automatic sweep0(input int restart_at, output int done_cyc, output int n_done,
                          output int busy_cnt, output logic order_ok, output int max_vi);
        int prev;
        done_cyc = -1; n_done = 0; busy_cnt = 0; order_ok = 1'b1; prev = 0; max_vi = 0;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start0 = (cyc == restart_at);
            if (cyc == 1 && !busy0) order_ok = 1'b0;
            if (busy0) begin
                busy_cnt++;
                if (cyc == 1 && vi0 != 4'd0) order_ok = 1'b0;
                if (int'(vi0) != prev && int'(vi0) != prev + 1) order_ok = 1'b0;
                if (vi0 != {a0, b0}) order_ok = 1'b0;
                prev = int'(vi0);
                if (int'(vi0) > max_vi) max_vi = int'(vi0);
            end
            if (done0) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        start0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a0, b0, vi0, busy0, done0, err0, pass0} !== 15'd0) begin
            errors++;
            $display("FAIL reset_dut0 got %h expected 0", {a0, b0, vi0, busy0, done0, err0, pass0});
        end
        checks++;
        if ({a1, b1, vi1, busy1, done1, err1, pass1} !== 15'd0) begin
            errors++;
            $display("FAIL reset_dut1 got %h expected 0", {a1, b1, vi1, busy1, done1, err1, pass1});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode(input logic [1:0] m, input string name);
        int dc, nd, bc, mx, exp_e;
        logic ok;
        mode0 = m;
        exp_e = model_errs(m);
        sweep0(0, dc, nd, bc, ok, mx);
        checks++;
        if (dc !== 49 || nd !== 1) begin
            errors++;
            $display("FAIL %s_done_time got cyc=%0d n=%0d expected cyc=49 n=1", name, dc, nd);
        end
        checks++;
        if (bc !== 48 || !ok || mx !== 15) begin
            errors++;
            $display("FAIL %s_busy_order got busy=%0d order=%0b max=%0d expected 48 1 15", name, bc, ok, mx);
        end
        checks++;
        if (int'(err0) !== exp_e || pass0 !== (exp_e == 0)) begin
            errors++;
            $display("FAIL %s_result got err=%0d pass=%0b expected err=%0d pass=%0b", name, err0, pass0, exp_e, exp_e == 0);
        end
        checks++;
        if (a0 !== 2'b11 || b0 !== 2'b11 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL %s_final_ops got a=%b b=%b busy=%b expected 11 11 0", name, a0, b0, busy0);
        end
`ifdef NAND_EXERCISER_FAIL_CAPTURE_EN
        checks++;
        if (int'(fidx0) !== model_first(m)) begin
            errors++;
            $display("FAIL %s_fail_idx got %0d expected %0d", name, fidx0, model_first(m));
        end
`endif
    endtask

    task automatic test_random_faults();
        for (int it = 0; it < 3; it++) begin
            for (int v = 0; v < 16; v++)
                mask[v] = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
            test_mode(2'd3, "random");
        end
    endtask

    task automatic test_start_ignored();
        int dc, nd, bc, mx;
        logic ok;
        mode0 = 2'd0;
        sweep0(10, dc, nd, bc, ok, mx);
        checks++;
        if (dc !== 49 || nd !== 1 || bc !== 48) begin
            errors++;
            $display("FAIL start_ignored got cyc=%0d n=%0d busy=%0d expected 49 1 48", dc, nd, bc);
        end
        checks++;
        if (busy0 !== 1'b0 || pass0 !== 1'b1 || err0 !== 5'd0) begin
            errors++;
            $display("FAIL start_ignored_idle got busy=%b pass=%b err=%0d expected 0 1 0", busy0, pass0, err0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        mode0 = 2'd2;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (19) @(negedge clk);
        checks++;
        if (err0 === 5'd0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_activity got err=%0d busy=%b expected err>0 busy=1", err0, busy0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a0, b0, vi0, busy0, done0, err0, pass0} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset got %h expected 0", {a0, b0, vi0, busy0, done0, err0, pass0});
        end
`ifdef NAND_EXERCISER_FAIL_CAPTURE_EN
        checks++;
        if (fidx0 !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_fail_idx got %0d expected 0", fidx0);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_mode(2'd0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        c1 = -1; c2 = -1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int c = 1; c <= 60 && c1 < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (done1) c1 = c;
        end
        checks++;
        if (c1 !== 33 || pass1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got cyc=%0d pass=%b expected 33 1", c1, pass1);
        end
        @(negedge clk);
        checks++;
        if (pass1 !== 1'b1 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got pass=%b done=%b busy=%b expected 1 0 0", pass1, done1, busy1);
        end
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        checks++;
        if (pass1 !== 1'b0 || busy1 !== 1'b1 || err1 !== 5'd0) begin
            errors++;
            $display("FAIL b2b_restart got pass=%b busy=%b err=%0d expected 0 1 0", pass1, busy1, err1);
        end
        for (int c = 1; c <= 60 && c2 < 0; c++) begin
            if (c > 1) @(negedge clk);
            if (done1) c2 = c;
        end
        checks++;
        if (c2 !== 33 || pass1 !== 1'b1 || err1 !== 5'd0) begin
            errors++;
            $display("FAIL b2b_second got cyc=%0d pass=%b err=%0d expected 33 1 0", c2, pass1, err1);
        end
    endtask

    initial begin
        for (int v = 0; v < 16; v++) mask[v] = 2'b00;
        test_reset();
        test_mode(2'd0, "nand");
        test_mode(2'd1, "stuck_high");
        test_mode(2'd2, "and_fault");
        test_random_faults();
        test_start_ignored();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
